// File: rtl/itype_decode_checker_if.sv
// Bundles the instruction tap, shadow-regfile init port, core writeback port
// and checker results shared between the I-type decode checker and its driver.
interface itype_decode_checker_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic [31:0]      instr;
    logic             rf_init_en;
    logic [4:0]       rf_init_idx;
    logic [XLEN-1:0]  rf_init_data;
    logic             dut_wb_valid;
    logic [4:0]       dut_wb_rd;
    logic [XLEN-1:0]  dut_wb_data;
    logic             exp_wb_valid;
    logic [4:0]       exp_wb_rd;
    logic [XLEN-1:0]  exp_wb_data;
    logic             illegal;
    logic             mismatch;
    logic [CNT_W-1:0] mismatch_count;
    logic [31:0]      checked_count;

    modport master (
        output instr_valid, instr, rf_init_en, rf_init_idx, rf_init_data,
        output dut_wb_valid, dut_wb_rd, dut_wb_data,
        input  exp_wb_valid, exp_wb_rd, exp_wb_data,
        input  illegal, mismatch, mismatch_count, checked_count
    );

    modport slave (
        input  instr_valid, instr, rf_init_en, rf_init_idx, rf_init_data,
        input  dut_wb_valid, dut_wb_rd, dut_wb_data,
        output exp_wb_valid, exp_wb_rd, exp_wb_data,
        output illegal, mismatch, mismatch_count, checked_count
    );
endinterface

// File: rtl/itype_decode_checker.sv
// Golden-model checker for I-type ALU instructions: executes each accepted word on a
// shadow register file, delays the result LATENCY cycles and compares it with the core.
module itype_decode_checker #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    itype_decode_checker_if.slave bus
);
    localparam logic [6:0] OP_IMM = 7'b0010011;

    logic [XLEN-1:0] rf_q [32];

    logic [11:0]     imm12;
    logic [4:0]      rs1;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      opcode;
    logic [4:0]      shamt;
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] imm_sx;
    logic [XLEN-1:0] result;
    logic            legal;
    logic            accept;
    logic            exec_wr;

    assign imm12  = bus.instr[31:20];
    assign rs1    = bus.instr[19:15];
    assign funct3 = bus.instr[14:12];
    assign rd     = bus.instr[11:7];
    assign opcode = bus.instr[6:0];
    assign shamt  = imm12[4:0];
    assign src    = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign imm_sx = {{(XLEN-12){imm12[11]}}, imm12};

    always_comb begin
        legal  = 1'b0;
        result = '0;
        if (opcode == OP_IMM) begin
            case (funct3)
                3'd0: begin legal = 1'b1; result = src + imm_sx; end
                3'd1: begin legal = (imm12[11:5] == 7'd0); result = src << shamt; end
                3'd2: begin legal = 1'b1; result = {{(XLEN-1){1'b0}}, $signed(src) < $signed(imm_sx)}; end
                3'd3: begin legal = 1'b1; result = {{(XLEN-1){1'b0}}, src < imm_sx}; end
                3'd4: begin legal = 1'b1; result = src ^ imm_sx; end
                3'd5: begin
                    legal  = (imm12[11:5] == 7'd0) || (imm12[11:5] == 7'b0100000);
                    result = imm12[10] ? $unsigned($signed(src) >>> shamt) : (src >> shamt);
                end
                3'd6: begin legal = 1'b1; result = src | imm_sx; end
                3'd7: begin legal = 1'b1; result = src & imm_sx; end
            endcase
        end
    end

    assign accept  = bus.instr_valid && !reset;
    assign exec_wr = accept && legal && (rd != 5'd0);

    // Execute write is issued last so it overrides an init write to the same register.
    always_ff @(posedge clk) begin
        if (bus.rf_init_en && (bus.rf_init_idx != 5'd0)) begin
            rf_q[bus.rf_init_idx] <= bus.rf_init_data;
        end
        if (exec_wr) begin
            rf_q[rd] <= result;
        end
    end

    logic            pipe_vld_q  [LATENCY];
    logic [4:0]      pipe_rd_q   [LATENCY];
    logic [XLEN-1:0] pipe_data_q [LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_rd_q[i]   <= '0;
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= exec_wr;
            pipe_rd_q[0]   <= exec_wr ? rd : 5'd0;
            pipe_data_q[0] <= exec_wr ? result : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_rd_q[i]   <= pipe_rd_q[i-1];
                pipe_data_q[i] <= pipe_data_q[i-1];
            end
        end
    end

    logic             exp_vld;
    logic             dut_vld_eff;
    logic             mismatch_d,  mismatch_q;
    logic             illegal_d,   illegal_q;
    logic [CNT_W-1:0] mcount_d,    mcount_q;
    logic [31:0]      checked_d,   checked_q;

    assign exp_vld     = pipe_vld_q[LATENCY-1];
    assign dut_vld_eff = bus.dut_wb_valid && (bus.dut_wb_rd != 5'd0);

    always_comb begin
        mismatch_d = (exp_vld != dut_vld_eff) ||
                     (exp_vld && dut_vld_eff &&
                      ((pipe_rd_q[LATENCY-1] != bus.dut_wb_rd) ||
                       (pipe_data_q[LATENCY-1] != bus.dut_wb_data)));
        illegal_d  = accept && !legal;
        checked_d  = checked_q + {31'd0, exp_vld};
        mcount_d   = mcount_q;
        if (mismatch_d && (mcount_q != '1)) begin
            mcount_d = mcount_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch_q <= 1'b0;
            illegal_q  <= 1'b0;
            mcount_q   <= '0;
            checked_q  <= '0;
        end else begin
            mismatch_q <= mismatch_d;
            illegal_q  <= illegal_d;
            mcount_q   <= mcount_d;
            checked_q  <= checked_d;
        end
    end

    assign bus.exp_wb_valid   = exp_vld;
    assign bus.exp_wb_rd      = pipe_rd_q[LATENCY-1];
    assign bus.exp_wb_data    = pipe_data_q[LATENCY-1];
    assign bus.illegal        = illegal_q;
    assign bus.mismatch       = mismatch_q;
    assign bus.mismatch_count = mcount_q;
    assign bus.checked_count  = checked_q;
endmodule

// File: tb/tb_itype_decode_checker.sv
// Self-checking bench for itype_decode_checker: decode vector table, hand-written
// mismatch/reset sequences and a randomized run against a reference model.
module tb_itype_decode_checker;
    localparam int XLEN    = 32;
    localparam int LATENCY = 2;
    localparam int CNT_W   = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    itype_decode_checker_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    itype_decode_checker #(.XLEN(XLEN), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] data;
    } pend_t;

    typedef struct {
        logic [31:0] instr;
        bit          expIll;
        bit          expValid;
        logic [4:0]  expRd;
        logic [31:0] expData;
    } vec_t;

    logic [31:0] mrf [32];
    pend_t       pending [$];
    int          cyc;
    logic        mExpV;
    logic [4:0]  mExpRd;
    logic [31:0] mExpData;
    logic        mIll;
    logic        mMis;
    logic [15:0] mMisCnt;
    logic [31:0] mChk;
    int          nChecks;
    int          nPass;
    vec_t        tbl [16];

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    // Reference semantics of one I-type word, reading the model register file.
    function automatic void refExec(input logic [31:0] w, output bit legal, output logic [31:0] res);
        logic [31:0] a;
        logic [31:0] b;
        int unsigned sh;
        logic [6:0]  top;
        a     = (w[19:15] == 5'd0) ? 32'd0 : mrf[w[19:15]];
        b     = {{20{w[31]}}, w[31:20]};
        sh    = w[24:20];
        top   = w[31:25];
        legal = 1'b0;
        res   = 32'd0;
        if (w[6:0] == 7'h13) begin
            case (w[14:12])
                3'd0: begin legal = 1'b1; res = a + b; end
                3'd1: begin legal = (top == 7'd0); res = a << sh; end
                3'd2: begin legal = 1'b1; res = (int'(a) < int'(b)) ? 32'd1 : 32'd0; end
                3'd3: begin legal = 1'b1; res = (a < b) ? 32'd1 : 32'd0; end
                3'd4: begin legal = 1'b1; res = a ^ b; end
                3'd5: begin
                    legal = (top == 7'd0) || (top == 7'h20);
                    res   = a >> sh;
                    if (top == 7'h20 && a[31]) res = res | ~(32'hFFFF_FFFF >> sh);
                end
                3'd6: begin legal = 1'b1; res = a | b; end
                3'd7: begin legal = 1'b1; res = a & b; end
            endcase
        end
    endfunction

    function automatic logic [31:0] randInstr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) == 0) return w;
        if (w[14:12] == 3'd1 && $urandom_range(0, 3) != 0) w[31:25] = 7'd0;
        if (w[14:12] == 3'd5 && $urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        w[6:0] = 7'h13;
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock: advance the model with the currently driven inputs, then compare.
    task automatic applyStimulus();
        bit          legal;
        logic [31:0] res;
        bit          dutEff;
        bit          nm;
        refExec(bus.instr, legal, res);
        if (reset) begin
            pending.delete();
            mIll    = 1'b0;
            mMis    = 1'b0;
            mMisCnt = 16'd0;
            mChk    = 32'd0;
        end else begin
            dutEff = bus.dut_wb_valid && (bus.dut_wb_rd != 5'd0);
            nm     = (mExpV != dutEff) ||
                     (mExpV && dutEff && (mExpRd != bus.dut_wb_rd || mExpData != bus.dut_wb_data));
            if (mExpV) mChk++;
            if (nm && mMisCnt != 16'hFFFF) mMisCnt++;
            mMis = nm;
            mIll = bus.instr_valid && !legal;
        end
        if (bus.rf_init_en && bus.rf_init_idx != 5'd0) mrf[bus.rf_init_idx] = bus.rf_init_data;
        if (!reset && bus.instr_valid && legal && bus.instr[11:7] != 5'd0) begin
            mrf[bus.instr[11:7]] = res;
            pending.push_back('{cyc + LATENCY, bus.instr[11:7], res});
        end
        cyc++;
        mExpV    = 1'b0;
        mExpRd   = 5'd0;
        mExpData = 32'd0;
        if (pending.size() > 0 && pending[0].due == cyc) begin
            mExpV    = 1'b1;
            mExpRd   = pending[0].rd;
            mExpData = pending[0].data;
            void'(pending.pop_front());
        end
        @(posedge clk);
        #1;
        checkOutput("exp_wb_valid", bus.exp_wb_valid, mExpV);
        if (mExpV) begin
            checkOutput("exp_wb_rd", bus.exp_wb_rd, mExpRd);
            checkOutput("exp_wb_data", bus.exp_wb_data, mExpData);
        end
        checkOutput("illegal", bus.illegal, mIll);
        checkOutput("mismatch", bus.mismatch, mMis);
        checkOutput("mismatch_count", bus.mismatch_count, mMisCnt);
        checkOutput("checked_count", bus.checked_count, mChk);
    endtask

    task automatic followModel();
        bus.dut_wb_valid = mExpV;
        bus.dut_wb_rd    = mExpRd;
        bus.dut_wb_data  = mExpData;
    endtask

    initial begin
        int pulses;
        int wbSeen;
        int r;
        nChecks = 0; nPass = 0; cyc = 0;
        mExpV = 0; mExpRd = 0; mExpData = 0; mIll = 0; mMis = 0; mMisCnt = 0; mChk = 0;
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        reset = 1'b1;
        bus.instr_valid = 0; bus.instr = 0;
        bus.rf_init_en = 0; bus.rf_init_idx = 0; bus.rf_init_data = 0;
        bus.dut_wb_valid = 0; bus.dut_wb_rd = 0; bus.dut_wb_data = 0;

        tbl[0]  = '{itype(12'd1,    5'd1, 3'd0, 5'd2),  1'b0, 1'b1, 5'd2,  32'h8000_0000};
        tbl[1]  = '{itype(12'd0,    5'd2, 3'd2, 5'd3),  1'b0, 1'b1, 5'd3,  32'h0000_0001};
        tbl[2]  = '{itype(12'h404,  5'd5, 3'd5, 5'd6),  1'b0, 1'b1, 5'd6,  32'hFF00_0000};
        tbl[3]  = '{itype(12'h004,  5'd5, 3'd5, 5'd7),  1'b0, 1'b1, 5'd7,  32'h0F00_0000};
        tbl[4]  = '{itype(12'hFFF,  5'd0, 3'd3, 5'd8),  1'b0, 1'b1, 5'd8,  32'h0000_0001};
        tbl[5]  = '{itype(12'h020,  5'd1, 3'd1, 5'd9),  1'b1, 1'b0, 5'd0,  32'h0};
        tbl[6]  = '{itype(12'd5,    5'd1, 3'd0, 5'd0),  1'b0, 1'b0, 5'd0,  32'h0};
        tbl[7]  = '{itype(12'hFFF,  5'd1, 3'd4, 5'd10), 1'b0, 1'b1, 5'd10, 32'h8000_0000};
        tbl[8]  = '{itype(12'h7FF,  5'd5, 3'd7, 5'd11), 1'b0, 1'b1, 5'd11, 32'h0000_0000};
        tbl[9]  = '{itype(12'h800,  5'd1, 3'd6, 5'd12), 1'b0, 1'b1, 5'd12, 32'hFFFF_FFFF};
        tbl[10] = '{itype(12'd1,    5'd1, 3'd1, 5'd13), 1'b0, 1'b1, 5'd13, 32'hFFFF_FFFE};
        tbl[11] = '{32'h0000_0033,                      1'b1, 1'b0, 5'd0,  32'h0};
        tbl[12] = '{itype(12'h604,  5'd1, 3'd5, 5'd14), 1'b1, 1'b0, 5'd0,  32'h0};
        tbl[13] = '{itype(12'd31,   5'd1, 3'd5, 5'd14), 1'b0, 1'b1, 5'd14, 32'h0000_0000};
        tbl[14] = '{itype(12'hFFF,  5'd5, 3'd2, 5'd15), 1'b0, 1'b1, 5'd15, 32'h0000_0001};
        tbl[15] = '{itype(12'd1,    5'd5, 3'd3, 5'd16), 1'b0, 1'b1, 5'd16, 32'h0000_0000};

        // Known contents for every shadow register while reset is held.
        bus.rf_init_en = 1;
        for (int i = 1; i < 32; i++) begin
            bus.rf_init_idx = 5'(i);
            bus.rf_init_data = $urandom;
            applyStimulus();
        end
        bus.rf_init_en = 0;

        bus.instr_valid = 1;
        bus.instr = itype(12'd1, 5'd1, 3'd0, 5'd2);
        repeat (3) applyStimulus();
        checkOutput("reset_exp_valid", bus.exp_wb_valid, 32'd0);
        checkOutput("reset_illegal", bus.illegal, 32'd0);
        checkOutput("reset_mismatch", bus.mismatch, 32'd0);
        checkOutput("reset_mcount", bus.mismatch_count, 32'd0);
        checkOutput("reset_checked", bus.checked_count, 32'd0);
        reset = 0;
        applyStimulus();
        bus.instr_valid = 0;
        for (int k = 1; k < LATENCY; k++) begin
            checkOutput("latency_early", bus.exp_wb_valid, 32'd0);
            applyStimulus();
        end
        checkOutput("latency_exact", bus.exp_wb_valid, 32'd1);
        applyStimulus();

        reset = 1; applyStimulus(); reset = 0;
        bus.rf_init_en = 1;
        bus.rf_init_idx = 5'd1; bus.rf_init_data = 32'h7FFF_FFFF; applyStimulus();
        bus.rf_init_idx = 5'd5; bus.rf_init_data = 32'hF000_0000; applyStimulus();
        bus.rf_init_en = 0;
        for (int i = 0; i < 16; i++) begin
            bus.instr_valid = 1;
            bus.instr = tbl[i].instr;
            applyStimulus();
            bus.instr_valid = 0;
            checkOutput("tbl_illegal", bus.illegal, tbl[i].expIll);
            repeat (LATENCY - 1) applyStimulus();
            checkOutput("tbl_exp_valid", bus.exp_wb_valid, tbl[i].expValid);
            if (tbl[i].expValid) begin
                checkOutput("tbl_exp_rd", bus.exp_wb_rd, tbl[i].expRd);
                checkOutput("tbl_exp_data", bus.exp_wb_data, tbl[i].expData);
            end
            applyStimulus();
        end

        // Three ADDIs; the core's second writeback is off by one.
        reset = 1; applyStimulus(); reset = 0;
        bus.rf_init_en = 1; bus.rf_init_idx = 5'd1; bus.rf_init_data = 32'd10;
        applyStimulus();
        bus.rf_init_en = 0;
        pulses = 0; wbSeen = 0;
        for (int k = 0; k < 3 + LATENCY + 2; k++) begin
            bus.instr_valid = (k < 3);
            bus.instr = itype(12'(k + 1), 5'd1, 3'd0, 5'(2 + k));
            followModel();
            bus.dut_wb_data = mExpData + ((mExpV && wbSeen == 1) ? 32'd1 : 32'd0);
            if (mExpV) wbSeen++;
            applyStimulus();
            if (bus.mismatch) pulses++;
        end
        checkOutput("offby1_pulses", pulses, 32'd1);
        checkOutput("offby1_mcount", bus.mismatch_count, 32'd1);
        checkOutput("offby1_checked", bus.checked_count, 32'd3);

        // Core omits a writeback entirely.
        pulses = 0;
        bus.dut_wb_valid = 0;
        bus.instr_valid = 1; bus.instr = itype(12'd0, 5'd1, 3'd0, 5'd9);
        applyStimulus();
        bus.instr_valid = 0;
        repeat (LATENCY + 2) begin
            applyStimulus();
            if (bus.mismatch) pulses++;
        end
        checkOutput("omit_pulses", pulses, 32'd1);
        checkOutput("omit_mcount", bus.mismatch_count, 32'd2);

        // rd==0 instruction and rd==0 core writes are both invisible.
        pulses = 0;
        bus.instr_valid = 1; bus.instr = itype(12'd5, 5'd1, 3'd0, 5'd0);
        applyStimulus();
        bus.instr_valid = 0;
        bus.dut_wb_valid = 1; bus.dut_wb_rd = 5'd0; bus.dut_wb_data = $urandom;
        repeat (LATENCY + 2) begin
            applyStimulus();
            if (bus.mismatch || bus.exp_wb_valid) pulses++;
        end
        checkOutput("x0_quiet", pulses, 32'd0);
        checkOutput("x0_mcount", bus.mismatch_count, 32'd2);
        bus.dut_wb_valid = 0;

        reset = 1; applyStimulus(); reset = 0;
        for (int k = 0; k < 3000; k++) begin
            bus.rf_init_en   = ($urandom_range(0, 3) == 0);
            bus.rf_init_idx  = 5'($urandom);
            bus.rf_init_data = $urandom;
            bus.instr_valid  = ($urandom_range(0, 3) != 0);
            bus.instr        = randInstr();
            if (bus.rf_init_en && $urandom_range(0, 1) == 1) bus.rf_init_idx = bus.instr[11:7];
            followModel();
            r = $urandom_range(0, 19);
            if (r == 0) bus.dut_wb_data = mExpData ^ (32'd1 << $urandom_range(0, 31));
            if (r == 1) begin bus.dut_wb_valid = !mExpV; bus.dut_wb_rd = 5'($urandom); end
            if (r == 2) bus.dut_wb_rd = mExpRd ^ 5'd1;
            applyStimulus();
        end
        bus.rf_init_en = 0; bus.instr_valid = 0;

        // Spurious core writes every cycle drive the counter into saturation.
        reset = 1; applyStimulus(); reset = 0;
        bus.dut_wb_valid = 1; bus.dut_wb_rd = 5'd1; bus.dut_wb_data = 32'd0;
        repeat ((1 << CNT_W) + 3) applyStimulus();
        checkOutput("sat_mcount", bus.mismatch_count, 32'h0000_FFFF);
        bus.dut_wb_valid = 0;

        // Reset with two entries in flight discards them.
        reset = 1; applyStimulus(); reset = 0;
        bus.instr_valid = 1;
        bus.instr = itype(12'd3, 5'd1, 3'd0, 5'd2); applyStimulus();
        bus.instr = itype(12'd4, 5'd1, 3'd0, 5'd3); applyStimulus();
        bus.instr_valid = 0;
        reset = 1; applyStimulus(); reset = 0;
        pulses = 0;
        repeat (LATENCY + 2) begin
            applyStimulus();
            if (bus.exp_wb_valid) pulses++;
        end
        checkOutput("midreset_no_exp", pulses, 32'd0);
        checkOutput("midreset_mcount", bus.mismatch_count, 32'd0);
        checkOutput("midreset_checked", bus.checked_count, 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
